// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel/line counters advanced by a pixel tick,
// registered sync/visible/colour outputs for the pixel at the current count,
// with a one-hot palette mode and a direct 12-bit RGB mode.
module vga_timing_gen #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int CW     = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_en,
  input  logic          enable,
  input  logic          mode,
  input  logic [7:0]    color,
  input  logic [11:0]   rgb_in,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic [3:0]    R,
  output logic [3:0]    G,
  output logic [3:0]    B,
  output logic          hsync,
  output logic          vsync,
  output logic          visible,
  output logic [2:0]    color_idx,
  output logic          color_err,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOT - 1);
  localparam logic [CW-1:0] H_VIS_C  = CW'(H_VIS);
  localparam logic [CW-1:0] V_VIS_C  = CW'(V_VIS);
  localparam logic [CW-1:0] HS_START = CW'(H_VIS + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_VIS + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_VIS + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_VIS + V_FP + V_SYNC);

  logic        pix_vis;
  logic        pix_hs;
  logic        pix_vs;
  logic        pal_ok;
  logic [2:0]  pal_idx;
  logic [11:0] pal_rgb;
  logic [11:0] pix_rgb;
  logic [2:0]  pix_idx;
  logic        pix_err;
  logic        advance;

  assign advance = enable & pix_en;

  // Pixel/line counters; idle (0,0) whenever the generator is disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (!enable) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_en) begin
      if (hcount == H_LAST) begin
        hcount <= '0;
        vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
      end else begin
        hcount <= hcount + 1'b1;
      end
    end
  end

  // Decode the pixel at the current count: area, syncs, palette and colour.
  always_comb begin
    pix_vis = (hcount < H_VIS_C) && (vcount < V_VIS_C);
    pix_hs  = ((hcount >= HS_START) && (hcount < HS_END)) ? HS_POL : ~HS_POL;
    pix_vs  = ((vcount >= VS_START) && (vcount < VS_END)) ? VS_POL : ~VS_POL;

    pal_ok  = 1'b1;
    pal_idx = 3'd0;
    pal_rgb = 12'h000;
    case (color)
      8'h01:   begin pal_idx = 3'd0; pal_rgb = 12'h000; end
      8'h02:   begin pal_idx = 3'd1; pal_rgb = 12'h00F; end
      8'h04:   begin pal_idx = 3'd2; pal_rgb = 12'h841; end
      8'h08:   begin pal_idx = 3'd3; pal_rgb = 12'h088; end
      8'h10:   begin pal_idx = 3'd4; pal_rgb = 12'hF00; end
      8'h20:   begin pal_idx = 3'd5; pal_rgb = 12'h808; end
      8'h40:   begin pal_idx = 3'd6; pal_rgb = 12'hFF0; end
      8'h80:   begin pal_idx = 3'd7; pal_rgb = 12'hFFF; end
      default: pal_ok = 1'b0;
    endcase

    if (mode) begin
      pix_rgb = rgb_in;
      pix_idx = 3'd0;
      pix_err = 1'b0;
    end else begin
      pix_rgb = pal_ok ? pal_rgb : 12'h000;
      pix_idx = pal_ok ? pal_idx : 3'd0;
      pix_err = ~pal_ok;
    end

    // Blanking always drives black and never flags a palette error.
    if (!pix_vis) begin
      pix_rgb = 12'h000;
      pix_idx = 3'd0;
      pix_err = 1'b0;
    end
  end

  // Register the decoded pixel on each pixel tick; pulses last one clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {R, G, B}   <= 12'h000;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      visible     <= 1'b0;
      color_idx   <= 3'd0;
      color_err   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (!enable) begin
      {R, G, B}   <= 12'h000;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      visible     <= 1'b0;
      color_idx   <= 3'd0;
      color_err   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (advance) begin
      {R, G, B}   <= pix_rgb;
      hsync       <= pix_hs;
      vsync       <= pix_vs;
      visible     <= pix_vis;
      color_idx   <= pix_idx;
      color_err   <= pix_err;
      line_start  <= (hcount == '0);
      frame_start <= (hcount == '0) && (vcount == '0);
    end else begin
      color_err   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with a reduced raster (15 x 8). A tick-count
// reference model derives every expected output from position arithmetic.
module tb_vga_timing_gen;

  localparam int HV = 8, HFP = 2, HSW = 3, HBP = 2;
  localparam int VV = 4, VFP = 1, VSW = 2, VBP = 1;
  localparam int HT = HV + HFP + HSW + HBP;
  localparam int VT = VV + VFP + VSW + VBP;
  localparam int FT = HT * VT;
  localparam int CW = 6;

  logic clk, reset, pix_en, enable, mode;
  logic [7:0]  color;
  logic [11:0] rgb_in;

  logic [CW-1:0] hcount, vcount, hcount_p, vcount_p;
  logic [3:0] R, G, B, R_p, G_p, B_p;
  logic hsync, vsync, visible, color_err, line_start, frame_start;
  logic hsync_p, vsync_p, visible_p, color_err_p, line_start_p, frame_start_p;
  logic [2:0] color_idx, color_idx_p;

  vga_timing_gen #(.H_VIS(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
                   .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
                   .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .enable(enable), .mode(mode),
    .color(color), .rgb_in(rgb_in), .hcount(hcount), .vcount(vcount),
    .R(R), .G(G), .B(B), .hsync(hsync), .vsync(vsync), .visible(visible),
    .color_idx(color_idx), .color_err(color_err), .line_start(line_start),
    .frame_start(frame_start));

  vga_timing_gen #(.H_VIS(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
                   .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
                   .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW)) dut_pos (
    .clk(clk), .reset(reset), .pix_en(pix_en), .enable(enable), .mode(mode),
    .color(color), .rgb_in(rgb_in), .hcount(hcount_p), .vcount(vcount_p),
    .R(R_p), .G(G_p), .B(B_p), .hsync(hsync_p), .vsync(vsync_p), .visible(visible_p),
    .color_idx(color_idx_p), .color_err(color_err_p), .line_start(line_start_p),
    .frame_start(frame_start_p));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: ticks since restart plus the last registered pixel.
  int          tick_n;
  logic [11:0] e_rgb;
  logic        e_hs, e_vs, e_hs2, e_vs2, e_vis, e_err, e_ls, e_fs;
  logic [2:0]  e_idx;
  logic        adv;

  logic [11:0] pal [8] = '{12'h000, 12'h00F, 12'h841, 12'h088,
                           12'hF00, 12'h808, 12'hFF0, 12'hFFF};

  typedef struct {
    logic        m;
    logic [7:0]  c;
    logic [11:0] rgb;
    logic [11:0] x_rgb;
    logic [2:0]  x_idx;
    logic        x_err;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h exp %h", name, $time, got, exp);
    end
  endtask

  task automatic set_idle();
    tick_n = 0;
    e_rgb = 12'h000; e_vis = 1'b0; e_idx = 3'd0;
    e_err = 1'b0; e_ls = 1'b0; e_fs = 1'b0;
    e_hs = 1'b1; e_vs = 1'b1; e_hs2 = 1'b0; e_vs2 = 1'b0;
  endtask

  task automatic check_all(input string name);
    logic [63:0] got, exp;
    got = {28'd0, hcount, vcount, R, G, B, hsync, vsync, visible, color_idx,
           color_err, line_start, frame_start, hsync_p, vsync_p};
    exp = {28'd0, CW'(tick_n % HT), CW'(tick_n / HT), e_rgb, e_hs, e_vs, e_vis,
           e_idx, e_err, e_ls, e_fs, e_hs2, e_vs2};
    chk(name, got, exp);
  endtask

  // One clock edge: capture pre-edge inputs, advance the model, compare.
  task automatic tick(input string name);
    logic rs, en, pe, m;
    logic [7:0] c;
    logic [11:0] rgb;
    int h, v, ones;
    logic hs_act, vs_act, vis;
    rs = reset; en = enable; pe = pix_en; m = mode; c = color; rgb = rgb_in;
    @(posedge clk);
    #1;
    adv = 1'b0;
    if (!rs || !en) begin
      set_idle();
    end else if (pe) begin
      adv = 1'b1;
      h = tick_n % HT;
      v = tick_n / HT;
      vis = (h < HV) && (v < VV);
      hs_act = (h >= HV + HFP) && (h < HV + HFP + HSW);
      vs_act = (v >= VV + VFP) && (v < VV + VFP + VSW);
      ones = $countones(c);
      e_vis = vis;
      e_hs = ~hs_act; e_hs2 = hs_act;
      e_vs = ~vs_act; e_vs2 = vs_act;
      e_ls = (h == 0);
      e_fs = (h == 0) && (v == 0);
      e_rgb = 12'h000; e_idx = 3'd0; e_err = 1'b0;
      if (vis) begin
        if (m) e_rgb = rgb;
        else if (ones == 1) begin
          e_idx = 3'($clog2(c));
          e_rgb = pal[$clog2(c)];
        end else e_err = 1'b1;
      end
      tick_n = (tick_n + 1) % FT;
    end else begin
      e_err = 1'b0; e_ls = 1'b0; e_fs = 1'b0;
    end
    check_all(name);
  endtask

  task automatic advance_to(input int target);
    int n;
    n = 0;
    pix_en = 1'b1;
    while (tick_n != target && n < 2 * FT) begin
      tick("seek");
      n++;
    end
    chk("seek_timeout", 64'(tick_n), 64'(target));
  endtask

  // Reset asserted between edges: outputs must fall to idle without a clock.
  task automatic async_reset(input string name);
    #2;
    reset = 1'b0;
    #1;
    set_idle();
    check_all(name);
    tick(name);
    tick(name);
    reset = 1'b1;
  endtask

  initial begin
    int vis_cnt, hs_cnt, hs2_cnt, vs_cnt, fs_cnt, ls_cnt, clk_n;

    vecs[0] = '{1'b0, 8'h01, 12'h123, 12'h000, 3'd0, 1'b0};
    vecs[1] = '{1'b0, 8'h02, 12'h000, 12'h00F, 3'd1, 1'b0};
    vecs[2] = '{1'b0, 8'h04, 12'h000, 12'h841, 3'd2, 1'b0};
    vecs[3] = '{1'b0, 8'h10, 12'h000, 12'hF00, 3'd4, 1'b0};
    vecs[4] = '{1'b0, 8'h80, 12'h000, 12'hFFF, 3'd7, 1'b0};
    vecs[5] = '{1'b0, 8'h03, 12'h000, 12'h000, 3'd0, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 12'h000, 12'h000, 3'd0, 1'b1};
    vecs[7] = '{1'b1, 8'h03, 12'hABC, 12'hABC, 3'd0, 1'b0};

    reset = 1'b0; enable = 1'b0; pix_en = 1'b0;
    mode = 1'b0; color = 8'h10; rgb_in = 12'h000;
    set_idle();
    adv = 1'b0;
    tick("reset");
    tick("reset");
    reset = 1'b1;
    tick("disabled");

    // Palette / direct vectors on the first visible pixels of line 0.
    enable = 1'b1;
    pix_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mode = vecs[i].m; color = vecs[i].c; rgb_in = vecs[i].rgb;
      tick("vec_model");
      chk($sformatf("vec%0d_rgb", i), 64'({R, G, B}), 64'(vecs[i].x_rgb));
      chk($sformatf("vec%0d_idx", i), 64'(color_idx), 64'(vecs[i].x_idx));
      chk($sformatf("vec%0d_err", i), 64'(color_err), 64'(vecs[i].x_err));
      if (i == 0) chk("first_tick_starts", 64'({frame_start, line_start}), 64'(2'b11));
    end

    // Illegal colour and direct colour inside horizontal blanking.
    mode = 1'b0; color = 8'h03;
    for (int i = 0; i < 3; i++) begin
      tick("blank_pal");
      chk("blank_no_err", 64'(color_err), 64'(0));
    end
    mode = 1'b1; rgb_in = 12'hABC;
    for (int i = 0; i < 4; i++) begin
      tick("blank_direct");
      chk("blank_black", 64'({R, G, B}), 64'(0));
    end
    tick("direct_vis");
    chk("direct_rgb", 64'({R, G, B}), 64'(12'hABC));

    // Two whole frames with a pixel tick every 4th clk.
    mode = 1'b0; color = 8'h10;
    vis_cnt = 0; hs_cnt = 0; hs2_cnt = 0; vs_cnt = 0; fs_cnt = 0; ls_cnt = 0; clk_n = 0;
    while ((vis_cnt + hs_cnt + vs_cnt) >= 0 && clk_n < 4 * 2 * FT) begin
      pix_en = (clk_n % 4 == 0);
      tick("frame_run");
      if (adv) begin
        vis_cnt += int'(visible);
        hs_cnt  += int'(!hsync);
        hs2_cnt += int'(hsync_p);
        vs_cnt  += int'(!vsync);
        fs_cnt  += int'(frame_start);
        ls_cnt  += int'(line_start);
      end
      clk_n++;
    end
    chk("frame_visible", 64'(vis_cnt), 64'(2 * HV * VV));
    chk("frame_hsync", 64'(hs_cnt), 64'(2 * HSW * VT));
    chk("frame_hsync_pos", 64'(hs2_cnt), 64'(2 * HSW * VT));
    chk("frame_vsync", 64'(vs_cnt), 64'(2 * VSW * HT));
    chk("frame_starts", 64'(fs_cnt), 64'(2));
    chk("line_starts", 64'(ls_cnt), 64'(2 * VT));

    // Enable dropped mid-frame for 10 clks.
    advance_to(2 * HT + 5);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick("en_drop");
      chk("en_drop_idle", 64'({hcount, vcount, visible}), 64'(0));
    end
    enable = 1'b1;
    tick("en_restart");
    chk("en_restart_fs", 64'({frame_start, line_start}), 64'(2'b11));

    // Asynchronous reset mid-frame.
    advance_to(3 * HT + 7);
    async_reset("async_reset");
    pix_en = 1'b1;
    tick("post_reset");
    chk("post_reset_fs", 64'({frame_start, line_start, visible}), 64'(3'b111));

    // Randomized run against the reference model.
    for (int i = 0; i < 3000; i++) begin
      pix_en = ($urandom_range(0, 2) != 0);
      mode = ($urandom_range(0, 3) == 0);
      color = ($urandom_range(0, 1) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'($urandom);
      rgb_in = 12'($urandom);
      enable = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 399) == 0) async_reset("rand_reset");
      else tick("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
